// File: rtl/rblwe_pkg.sv
// Shared definitions for the RB-LWE operation scheduler: opcodes, widths,
// scheduler FSM states and the opcode legality check.
package rblwe_pkg;

    localparam int POLY_W = 32;
    localparam int H_W    = 36;

    localparam logic [4:0] OP_POLYMUL = 5'b00001;
    localparam logic [4:0] OP_POLYADD = 5'b00010;
    localparam logic [4:0] OP_BINADD  = 5'b00011;
    localparam logic [4:0] OP_SAMPLE  = 5'b00100;
    localparam logic [4:0] OP_ADDE    = 5'b00110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

    function automatic logic is_legal_op(input logic [4:0] op);
        case (op)
            OP_POLYMUL, OP_POLYADD, OP_BINADD, OP_SAMPLE, OP_ADDE: return 1'b1;
            default:                                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rblwe_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request searching
// upward from the index after last_grant_i, wrapping modulo NUM_REQ.
module rblwe_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
    output logic                       grant_valid_o
);

    localparam int ID_W = $clog2(NUM_REQ);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the search so no path leaves a latch.
        idx           = 0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_grant_i) + i) % NUM_REQ;
            if (!grant_valid_o && req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = ID_W'(idx);
            end
        end
        grant_o = grant_valid_o ? (NUM_REQ'(1) << grant_idx_o) : '0;
    end

endmodule

// File: rtl/rblwe_op_scheduler.sv
// Round-robin scheduler sharing one RB-LWE accelerator between NUM_REQ requesters.
// Optional WAIT-state timeout/abort is enabled by defining RBLWE_SCHED_TIMEOUT_EN.
module rblwe_op_scheduler
    import rblwe_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [5*NUM_REQ-1:0]        req_opcode,
    input  logic [32*NUM_REQ-1:0]       req_d,
    input  logic [32*NUM_REQ-1:0]       req_b,
    input  logic [32*NUM_REQ-1:0]       req_g,
    input  logic [36*NUM_REQ-1:0]       req_h,
    input  logic [NUM_REQ-1:0]          req_use_h,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [35:0]                 rsp_data,
    output logic                        rsp_error,
    output logic                        acc_start,
    output logic [4:0]                  acc_opcode,
    output logic [31:0]                 acc_d,
    output logic [31:0]                 acc_b,
    output logic [31:0]                 acc_g,
    output logic [35:0]                 acc_h,
    input  logic [35:0]                 acc_w,
    input  logic                        acc_valid,
    input  logic                        acc_done,
    output logic                        acc_rst_n
);

    localparam int ID_W = $clog2(NUM_REQ);

    sched_state_e      state_q, state_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [H_W-1:0]    h_q, h_d;
    logic [4:0]        op_q, op_d;
    logic [POLY_W-1:0] d_q, d_d, b_q, b_d, g_q, g_d;
    logic [H_W-1:0]    hop_q, hop_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [H_W-1:0]    rsp_data_q, rsp_data_d;
    logic              rsp_error_q, rsp_error_d;

    logic [NUM_REQ-1:0] grant_oh;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic               abort_pulse;
    logic               unused_in;

    rblwe_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i         (req_valid),
        .last_grant_i  (last_grant_q),
        .grant_o       (grant_oh),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_any)
    );

    logic [4:0]        sel_op;
    logic [POLY_W-1:0] sel_d, sel_b, sel_g;
    logic [H_W-1:0]    sel_h;

    assign sel_op = req_opcode[5*grant_idx +: 5];
    assign sel_d  = req_d[POLY_W*grant_idx +: POLY_W];
    assign sel_b  = req_b[POLY_W*grant_idx +: POLY_W];
    assign sel_g  = req_g[POLY_W*grant_idx +: POLY_W];
    assign sel_h  = req_use_h[grant_idx] ? h_q : req_h[H_W*grant_idx +: H_W];

`ifdef RBLWE_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    assign wait_cnt_d  = (state_q == WAIT && !acc_done) ? wait_cnt_q + 1'b1 : '0;
    assign abort_pulse = (state_q == WAIT) && !acc_done
                         && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wait_cnt_q <= '0;
        else       wait_cnt_q <= wait_cnt_d;
    end
`else
    assign abort_pulse = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        h_d          = h_q;
        op_d         = op_q;
        d_d          = d_q;
        b_d          = b_q;
        g_d          = g_q;
        hop_d        = hop_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_error_d  = rsp_error_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    rsp_id_d = grant_idx;
                    if (is_legal_op(sel_op)) begin
                        op_d    = sel_op;
                        d_d     = sel_d;
                        b_d     = sel_b;
                        g_d     = sel_g;
                        hop_d   = sel_h;
                        state_d = ISSUE;
                    end else begin
                        // Illegal opcodes bypass the accelerator entirely.
                        rsp_data_d  = '0;
                        rsp_error_d = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (acc_done) begin
                    rsp_data_d  = acc_w;
                    rsp_error_d = 1'b0;
                    if (op_q == OP_SAMPLE) h_d = acc_w;
                    state_d = RESP;
                end else if (abort_pulse) begin
                    rsp_data_d  = '0;
                    rsp_error_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    last_grant_d = rsp_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            h_q          <= '0;
            op_q         <= '0;
            d_q          <= '0;
            b_q          <= '0;
            g_q          <= '0;
            hop_q        <= '0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            h_q          <= h_d;
            op_q         <= op_d;
            d_q          <= d_d;
            b_q          <= b_d;
            g_q          <= g_d;
            hop_q        <= hop_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_error_q  <= rsp_error_d;
        end
    end

    // Grants are gated by reset so nothing is offered while the block is held.
    assign req_ready  = grant_oh & {NUM_REQ{(state_q == IDLE) && !reset}};
    assign acc_start  = (state_q == ISSUE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_error  = rsp_error_q;
    assign acc_opcode = op_q;
    assign acc_d      = d_q;
    assign acc_b      = b_q;
    assign acc_g      = g_q;
    assign acc_h      = hop_q;
    assign acc_rst_n  = ~reset & ~abort_pulse;

    assign unused_in = acc_valid ^ (TIMEOUT_CYCLES < 1);

endmodule

// File: tb/tb_rblwe_op_scheduler.sv
// Directed bench for rblwe_op_scheduler with a small accelerator stub
// (3-cycle done latency, 7 cycles for SAMPLE).
module tb_rblwe_op_scheduler;
    import rblwe_pkg::*;

    localparam int N = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_ready, req_use_h;
    logic [5*N-1:0]  req_opcode;
    logic [32*N-1:0] req_d, req_b, req_g;
    logic [36*N-1:0] req_h;
    logic            rsp_valid, rsp_ready, rsp_error;
    logic [0:0]      rsp_id;
    logic [35:0]     rsp_data;
    logic            acc_start, acc_rst_n;
    logic [4:0]      acc_opcode;
    logic [31:0]     acc_d, acc_b, acc_g;
    logic [35:0]     acc_h;
    logic [35:0]     acc_w     = '0;
    logic            acc_valid = 1'b0;
    logic            acc_done  = 1'b0;

    rblwe_op_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_d(req_d), .req_b(req_b), .req_g(req_g), .req_h(req_h), .req_use_h(req_use_h),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_error(rsp_error),
        .acc_start(acc_start), .acc_opcode(acc_opcode), .acc_d(acc_d), .acc_b(acc_b),
        .acc_g(acc_g), .acc_h(acc_h), .acc_w(acc_w), .acc_valid(acc_valid),
        .acc_done(acc_done), .acc_rst_n(acc_rst_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Toy accelerator arithmetic; only its outputs for the directed operands matter.
    function automatic logic [35:0] acc_fn(input logic [4:0] op, input logic [31:0] d,
                                           input logic [31:0] b, input logic [31:0] g,
                                           input logic [35:0] h);
        case (op)
            OP_POLYMUL: return {4'h0, d * g + b};
            OP_POLYADD: return 36'((d + g) % 7);
            OP_BINADD:  return {4'h0, d} + h;
            OP_SAMPLE:  return {4'hA, d ^ 32'h1234_5678};
            OP_ADDE:    return {4'h0, h[31:0] + d + g};
            default:    return '0;
        endcase
    endfunction

    logic        busy_m     = 1'b0;
    int          cnt_m      = 0;
    logic [35:0] w_m        = '0;
    logic        never_done = 1'b0;

    always @(posedge clk) begin
        acc_done  <= 1'b0;
        acc_valid <= 1'b0;
        if (!acc_rst_n) begin
            busy_m <= 1'b0;
        end else if (acc_start) begin
            busy_m <= 1'b1;
            cnt_m  <= (acc_opcode == OP_SAMPLE) ? 5 : 1;
            w_m    <= acc_fn(acc_opcode, acc_d, acc_b, acc_g, acc_h);
        end else if (busy_m) begin
            if (cnt_m != 0) cnt_m <= cnt_m - 1;
            else if (!never_done) begin
                acc_done  <= 1'b1;
                acc_valid <= 1'b1;
                acc_w     <= w_m;
                busy_m    <= 1'b0;
            end
        end
    end

    int cyc = 0;
    int start_cnt = 0;
    int start_q[$];
    always @(posedge clk) begin
        cyc++;
        if (acc_start === 1'b1) begin
            start_cnt++;
            start_q.push_back(cyc);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int id, input logic [4:0] op, input logic [31:0] d,
                           input logic [31:0] b, input logic [31:0] g,
                           input logic [35:0] h, input logic use_h);
        req_opcode[5*id +: 5] = op;
        req_d[32*id +: 32]    = d;
        req_b[32*id +: 32]    = b;
        req_g[32*id +: 32]    = g;
        req_h[36*id +: 36]    = h;
        req_use_h[id]         = use_h;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_txn(input int id, input logic [4:0] op, input logic [31:0] d,
                           input logic [31:0] b, input logic [31:0] g,
                           input logic [35:0] h, input logic use_h,
                           output int lat, output logic [35:0] data, output logic err,
                           output int rid, output logic rdy, output int starts);
        int s0;
        int w;
        s0 = start_cnt;
        set_req(id, op, d, b, g, h, use_h);
        req_valid     = '0;
        req_valid[id] = 1'b1;
        #1;
        rdy = req_ready[id];
        tick();
        req_valid = '0;
        wait_rsp(w);
        lat  = w + 1;
        data = rsp_data;
        err  = rsp_error;
        rid  = int'(rsp_id);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        starts = start_cnt - s0;
    endtask

    function automatic int qget(input int q[$], input int k);
        return (q.size() > k) ? q[k] : -1;
    endfunction

    typedef struct {
        string       name;
        int          id;
        logic [4:0]  op;
        logic [31:0] d, b, g;
        logic [35:0] h;
        logic        use_h;
        logic [35:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_starts;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat, rid, st, w, base, abort_at, low_cnt;
        logic [35:0] data, snap_data;
        logic err, rdy, stable;
        int grants[$];
        int rsp_ids[$];
        int rsp_dat[$];

        vecs[0] = '{"binadd",     0, OP_BINADD,  32'h0000_FFFF, 32'd0, 32'd0, 36'h0_FFFF_0000, 1'b0, 36'h0_FFFF_FFFF, 1'b0, 5, 1};
        vecs[1] = '{"polymul",    1, OP_POLYMUL, 32'd3,         32'd1, 32'd7, 36'h0,           1'b0, 36'h16,          1'b0, 5, 1};
        vecs[2] = '{"polyadd",    0, OP_POLYADD, 32'd5,         32'd0, 32'd4, 36'h0,           1'b0, 36'h2,           1'b0, 5, 1};
        vecs[3] = '{"adde",       1, OP_ADDE,    32'd1,         32'd0, 32'd2, 36'hF_0000_0010, 1'b0, 36'h13,          1'b0, 5, 1};
        vecs[4] = '{"illegal7",   0, 5'b00111,   32'd9,         32'd9, 32'd9, 36'h9,           1'b0, 36'h0,           1'b1, 1, 0};
        vecs[5] = '{"illegal0",   1, 5'b00000,   32'd1,         32'd1, 32'd1, 36'h1,           1'b0, 36'h0,           1'b1, 1, 0};
        vecs[6] = '{"sample",     0, OP_SAMPLE,  32'h11,        32'd0, 32'd0, 36'h0,           1'b0, 36'hA_1234_5669, 1'b0, 9, 1};
        vecs[7] = '{"adde_h",     1, OP_ADDE,    32'd0,         32'd0, 32'd0, 36'h5_5555_5555, 1'b1, 36'h0_1234_5669, 1'b0, 5, 1};
        vecs[8] = '{"illegal_hi", 1, 5'b11111,   32'd0,         32'd0, 32'd0, 36'h0,           1'b0, 36'h0,           1'b1, 1, 0};

        reset      = 1'b1;
        req_valid  = '0;
        req_use_h  = '0;
        req_opcode = '0;
        req_d = '0; req_b = '0; req_g = '0; req_h = '0;
        rsp_ready  = 1'b0;
        tick();
        req_valid = 2'b11;
        tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_acc_start", acc_start, 0);
        check("rst_acc_rst_n", acc_rst_n, 0);
        check("rst_rsp_data", {rsp_error, rsp_id, rsp_data}, 0);
        check("rst_acc_ops", {acc_opcode, acc_d, acc_h[26:0]}, 0);
        req_valid = '0;
        reset = 1'b0;
        tick();
        check("acc_rst_n_release", acc_rst_n, 1);

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].id, vecs[i].op, vecs[i].d, vecs[i].b, vecs[i].g, vecs[i].h,
                    vecs[i].use_h, lat, data, err, rid, rdy, st);
            check({vecs[i].name, "_ready"},  rdy,  1);
            check({vecs[i].name, "_id"},     rid,  vecs[i].id);
            check({vecs[i].name, "_data"},   data, vecs[i].exp_data);
            check({vecs[i].name, "_err"},    err,  vecs[i].exp_err);
            check({vecs[i].name, "_lat"},    lat,  vecs[i].exp_lat);
            check({vecs[i].name, "_starts"}, st,   vecs[i].exp_starts);
        end

        // Both requesters continuously valid: grants rotate 0,1,0.
        set_req(0, OP_POLYADD, 32'd5, 32'd0, 32'd4, 36'h0, 1'b0);
        set_req(1, OP_POLYADD, 32'd5, 32'd0, 32'd4, 36'h0, 1'b0);
        base = start_q.size();
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int c = 0; c < 80 && rsp_ids.size() < 3; c++) begin
            #1;
            if (req_ready != 0 && grants.size() < 3) grants.push_back(req_ready[1] ? 1 : 0);
            if (rsp_valid) begin
                rsp_ids.push_back(int'(rsp_id));
                rsp_dat.push_back(int'(rsp_data));
            end
            tick();
            if (grants.size() == 3) req_valid = '0;
        end
        rsp_ready = 1'b0;
        req_valid = '0;
        check("rot_grant0", qget(grants, 0), 0);
        check("rot_grant1", qget(grants, 1), 1);
        check("rot_grant2", qget(grants, 2), 0);
        check("rot_rsp_id1", qget(rsp_ids, 1), 1);
        check("rot_data0", qget(rsp_dat, 0), 2);
        check("rot_data1", qget(rsp_dat, 1), 2);
        check("rot_start_gap", qget(start_q, base + 1) - qget(start_q, base), 6);

        // Consumer stall in RESP while the other requester waits.
        tick();
        set_req(0, OP_POLYADD, 32'd5, 32'd0, 32'd4, 36'h0, 1'b0);
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        wait_rsp(w);
        snap_data = rsp_data;
        set_req(1, OP_POLYMUL, 32'd3, 32'd1, 32'd7, 36'h0, 1'b0);
        req_valid = 2'b10;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (!rsp_valid || rsp_data !== snap_data || rsp_id !== 1'b0 || req_ready !== 2'b00)
                stable = 1'b0;
            tick();
        end
        check("stall_stable", stable, 1);
        check("stall_data", snap_data, 36'h2);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        check("stall_next_grant", req_ready, 2'b10);
        tick();
        req_valid = '0;
        wait_rsp(w);
        check("stall_next_data", rsp_data, 36'h16);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset asserted mid-WAIT of a SAMPLE discards it and clears h_reg.
        set_req(0, OP_SAMPLE, 32'h77, 32'd0, 32'd0, 36'h0, 1'b0);
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midrst_ctrl", {rsp_valid, acc_start, acc_rst_n, req_ready}, 0);
        check("midrst_rsp", {rsp_error, rsp_id, rsp_data}, 0);
        check("midrst_acc", {acc_opcode, acc_d, acc_h[26:0]}, 0);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        check("midrst_no_late_rsp", rsp_valid, 0);
        set_req(0, OP_ADDE, 32'd0, 32'd0, 32'd0, 36'h3_3333_3333, 1'b1);
        set_req(1, OP_ADDE, 32'd0, 32'd0, 32'd0, 36'h3_3333_3333, 1'b1);
        req_valid = 2'b11;
        #1;
        check("midrst_first_grant", req_ready, 2'b01);
        tick();
        req_valid = '0;
        wait_rsp(w);
        check("midrst_h_cleared", rsp_data, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Accelerator that never completes.
        never_done = 1'b1;
        abort_at = -1;
        low_cnt = 0;
        set_req(1, OP_POLYMUL, 32'd3, 32'd1, 32'd7, 36'h0, 1'b0);
        req_valid = 2'b10;
        tick();
        req_valid = '0;
        for (int k = 1; k <= 100; k++) begin
            if (!acc_rst_n) begin
                low_cnt++;
                if (abort_at < 0) abort_at = k;
            end
            if (rsp_valid) break;
            tick();
        end
`ifdef RBLWE_SCHED_TIMEOUT_EN
        check("to_abort_cycle", abort_at, 66);
        check("to_abort_width", low_cnt, 1);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp", {rsp_error, rsp_data}, {1'b1, 36'h0});
        never_done = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`else
        check("nto_no_abort", low_cnt, 0);
        check("nto_still_waiting", rsp_valid, 0);
        never_done = 1'b0;
        wait_rsp(w);
        check("nto_late_done_data", {rsp_error, rsp_data}, {1'b0, 36'h16});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rblwe_op_scheduler.md
# rblwe_op_scheduler

Round-robin scheduler that shares one `rblwe_accelerator_top` instance between `NUM_REQ` requesters (e.g. key-gen, encrypt, decrypt engines). It accepts one operation at a time and issues it to the accelerator with a single-cycle start pulse. It waits for the accelerator's done, then returns the 36-bit result tagged with the requester index. It also keeps the last SAMPLE result as a shared H register, so requesters can chain SAMPLE → BINADD/ADDE without round-tripping H.

## Interface

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before abort (used only with the timeout feature)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot grant pulse; request accepted when valid & ready
- req_opcode  in  5*NUM_REQ  packed opcode, requester i at [5i+4:5i]
- req_d / req_b / req_g  in  32*NUM_REQ each  packed operands
- req_h  in  36*NUM_REQ  packed H operand
- req_use_h  in  NUM_REQ  1 = replace req_h with internal h_reg
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  response consumer ready
- rsp_id  out  $clog2(NUM_REQ)  requester index of the response
- rsp_data  out  36  result
- rsp_error  out  1  illegal opcode or timeout
- acc_start, acc_opcode[4:0], acc_d/acc_b/acc_g[31:0], acc_h[35:0]  out  to accelerator
- acc_w[35:0], acc_valid, acc_done  in  from accelerator
- acc_rst_n  out  1  accelerator reset, = ~reset & ~abort_pulse

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**:
  - If any req_valid, grant the first valid index searching from (last_grant+1) mod NUM_REQ upward.
  - Assert req_ready[grant] for exactly that cycle.
  - Latch opcode and operands; acc_h = req_use_h ? h_reg : req_h.
  - Legal opcodes are 00001 (POLYMUL), 00010 (POLYADD), 00011 (BINADD), 00100 (SAMPLE) and 00110 (ADDE).
  - Legal opcode → ISSUE. Illegal opcode → RESP with rsp_error=1, rsp_data=0; the accelerator is not touched.
- **ISSUE**:
  - acc_start=1 for one cycle → WAIT.
  - acc_opcode/d/b/g/h are held stable from ISSUE until WAIT exits.
- **WAIT**: on acc_done, capture acc_w into rsp_data, rsp_error=0 → RESP. If opcode was SAMPLE, h_reg ← acc_w on the same edge.
- **RESP**: rsp_valid=1 and stable until rsp_valid & rsp_ready. Then update last_grant ← rsp_id and return to IDLE.
- acc_valid is ignored for control; only acc_done advances the FSM.
- Reset values:
  - state = IDLE; last_grant = NUM_REQ-1, so requester 0 wins first.
  - h_reg = 0; req_ready = 0; rsp_valid = 0; rsp_id = 0; rsp_data = 0; rsp_error = 0.
  - acc_start = 0; all acc_* operand outputs = 0.
- Reset mid-operation: the whole FSM returns to IDLE and any in-flight result is discarded. The accelerator is also reset via acc_rst_n.

## Timing

- Accept cycle T. Then:
  - acc_start high in T+1.
  - POLYMUL/POLYADD/BINADD/ADDE: acc_done is seen in T+4 and rsp_valid rises in T+5.
  - SAMPLE: rsp_valid rises in T+9.
- Minimum spacing between acc_start pulses is 6 cycles. This covers the accelerator's one-cycle done pulse, so start never overlaps done.
- Requests arriving during ISSUE/WAIT/RESP wait in IDLE arbitration. req_ready never asserts outside IDLE.
- Simultaneous valids: exactly one grant per transaction, and fairness is strict rotation. With all requesters continuously valid, the grants run 0,1,…,NUM_REQ-1,0.
- rsp_ready held low: the FSM stalls in RESP indefinitely with rsp_* stable.

## Configuration

- `RBLWE_SCHED_TIMEOUT_EN` defined:
  - WAIT counts cycles. When the count reaches TIMEOUT_CYCLES without acc_done, acc_rst_n is pulsed low for one cycle (abort_pulse).
  - The FSM then goes to RESP with rsp_error=1 and rsp_data=0; h_reg is unchanged.
- Undefined: no counter; WAIT waits forever; abort_pulse is tied 0.

## Structure

- Package `rblwe_pkg`:
  - opcode localparams OP_POLYMUL, OP_POLYADD, OP_BINADD, OP_SAMPLE, OP_ADDE;
  - function is_legal_op;
  - widths POLY_W=32, H_W=36;
  - state enum.
- Sub-module `rblwe_rr_arbiter` (NUM_REQ): inputs req vector and last_grant; outputs one-hot grant and grant index. Purely combinational.

## Test plan

- Reset, then requester 0 issues BINADD with D=0x0000FFFF, H=0x0FFFF0000 → rsp_id=0, rsp_data=0x0FFFFFFFF, rsp_error=0, rsp_valid in T+5.
- Req0 and req1 both valid with POLYADD (D=5, G=4) → grant order 0 then 1, both rsp_data=2, second acc_start ≥6 cycles after first.
- Req1 SAMPLE, then req0 ADDE with use_h=1, D=G=0 → ADDE rsp_data equals SAMPLE rsp_data[31:0], zero-extended.
- Opcode 00111 → rsp_error=1, rsp_data=0 in T+1, acc_start never asserted.
- rsp_ready low for 10 cycles during RESP → rsp_* stable, no new req_ready; reset asserted mid-WAIT → all outputs at reset values next cycle.
- With `RBLWE_SCHED_TIMEOUT_EN` and the accelerator model never asserting done → after 64 WAIT cycles, one-cycle acc_rst_n low, rsp_error=1.
